// File: rtl/raster_pkg.sv
// ---------------------------------------------------------------------------
// raster_pkg: shared fixed-point types, screen limits and scanner state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package raster_pkg;

  localparam int INTEGER   = 10;
  localparam int DECIMAL   = 7;
  localparam int PRECISION = 1 + INTEGER + DECIMAL;
  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int PIX_W     = 10;

  typedef logic signed [PRECISION-1:0] fx_t;
  typedef logic [PIX_W-1:0]            pix_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_AREA  = 3'd2,
    ST_CLIP  = 3'd3,
    ST_SCAN  = 3'd4
  } scan_state_e;

  // Pixel centre (p + 0.5) in fixed point.
  function automatic fx_t sample_point(input pix_t p);
    return fx_t'({p, 1'b1, {(DECIMAL-1){1'b0}}});
  endfunction

endpackage

`default_nettype wire

// File: rtl/bbox_clip.sv
// ---------------------------------------------------------------------------
// bbox_clip: floor/min/max of three vertices, clamped to the screen, with empty flag.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bbox_clip
  import raster_pkg::*;
(
  input  logic [3*PRECISION-1:0] vx_i,
  input  logic [3*PRECISION-1:0] vy_i,
  output pix_t                   xmin_o,
  output pix_t                   xmax_o,
  output pix_t                   ymin_o,
  output pix_t                   ymax_o,
  output logic                   empty_o
);

  localparam int CW = INTEGER + 1;
  typedef logic signed [CW-1:0] crd_t;

  crd_t w_fx [3];
  crd_t w_fy [3];
  crd_t w_xlo, w_xhi, w_ylo, w_yhi;
  crd_t w_xmin, w_xmax, w_ymin, w_ymax;

  function automatic crd_t min3(input crd_t a, input crd_t b, input crd_t c);
    crd_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic crd_t max3(input crd_t a, input crd_t b, input crd_t c);
    crd_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_floor
    assign w_fx[i] = crd_t'(fx_t'(vx_i[i*PRECISION +: PRECISION]) >>> DECIMAL);
    assign w_fy[i] = crd_t'(fx_t'(vy_i[i*PRECISION +: PRECISION]) >>> DECIMAL);
  end

  assign w_xlo = min3(w_fx[0], w_fx[1], w_fx[2]);
  assign w_xhi = max3(w_fx[0], w_fx[1], w_fx[2]);
  assign w_ylo = min3(w_fy[0], w_fy[1], w_fy[2]);
  assign w_yhi = max3(w_fy[0], w_fy[1], w_fy[2]);

  assign w_xmin = (w_xlo < crd_t'(0))       ? crd_t'(0)       : w_xlo;
  assign w_xmax = (w_xhi > crd_t'(H_RES-1)) ? crd_t'(H_RES-1) : w_xhi;
  assign w_ymin = (w_ylo < crd_t'(0))       ? crd_t'(0)       : w_ylo;
  assign w_ymax = (w_yhi > crd_t'(V_RES-1)) ? crd_t'(V_RES-1) : w_yhi;

  // Clamped bounds are only meaningful when not empty, so truncation is safe.
  assign empty_o = (w_xmax < w_xmin) || (w_ymax < w_ymin);
  assign xmin_o  = pix_t'(w_xmin);
  assign xmax_o  = pix_t'(w_xmax);
  assign ymin_o  = pix_t'(w_ymin);
  assign ymax_o  = pix_t'(w_ymax);

endmodule

`default_nettype wire

// File: rtl/tri_pixel_scanner.sv
// ---------------------------------------------------------------------------
// tri_pixel_scanner: accepts a triangle, clips its bounding box and streams per-pixel
// edge operands in raster order. Optional AREA culling stage: TRI_BACKFACE_CULL_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tri_pixel_scanner
  import raster_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tri_vld_i,
  output logic                   tri_rdy_o,
  input  logic [3*PRECISION-1:0] tri_x_i,
  input  logic [3*PRECISION-1:0] tri_y_i,
  input  logic                   out_stall_i,
  output logic                   out_vld_o,
  output logic [3*PRECISION-1:0] out_ax_o,
  output logic [3*PRECISION-1:0] out_ay_o,
  output logic [3*PRECISION-1:0] out_bx_o,
  output logic [3*PRECISION-1:0] out_by_o,
  output logic [PIX_W-1:0]       out_px_o,
  output logic [PIX_W-1:0]       out_py_o,
  output logic                   out_last_o
);

  localparam int VW = 3 * PRECISION;

  scan_state_e state_q, state_d;

  fx_t  vx_q [3];
  fx_t  vy_q [3];
  fx_t  ax_q [3];
  fx_t  ay_q [3];
  pix_t xmin_q, xmax_q, ymin_q, ymax_q;
  pix_t px_q, py_q;
  logic done_q;
  logic armed_q;

  logic [VW-1:0]    out_ax_q, out_ay_q, out_bx_q, out_by_q;
  logic [PIX_W-1:0] out_px_q, out_py_q;
  logic             out_vld_q, out_last_q;

  pix_t w_xmin, w_xmax, w_ymin, w_ymax;
  logic w_box_empty, w_cull, w_empty;
  logic w_accept, w_is_last, w_emit;
  fx_t  w_sx, w_sy;

  bbox_clip u_bbox (
    .vx_i    ({vx_q[2], vx_q[1], vx_q[0]}),
    .vy_i    ({vy_q[2], vy_q[1], vy_q[0]}),
    .xmin_o  (w_xmin),
    .xmax_o  (w_xmax),
    .ymin_o  (w_ymin),
    .ymax_o  (w_ymax),
    .empty_o (w_box_empty)
  );

`ifdef TRI_BACKFACE_CULL_EN
  typedef logic signed [2*PRECISION-1:0] prod_t;
  typedef logic signed [2*PRECISION:0]   area_t;

  function automatic prod_t widen(input fx_t v);
    return {{PRECISION{v[PRECISION-1]}}, v};
  endfunction

  fx_t   w_a2p_x, w_a2p_y;
  prod_t w_p0, w_p1;
  area_t area_q;

  // Signed area a0 x (v2 - v0); non-positive means clockwise or degenerate.
  assign w_a2p_x = vx_q[2] - vx_q[0];
  assign w_a2p_y = vy_q[2] - vy_q[0];
  assign w_p0    = widen(ax_q[0]) * widen(w_a2p_y);
  assign w_p1    = widen(ay_q[0]) * widen(w_a2p_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      area_q <= '0;
    end else if (state_q == ST_AREA) begin
      area_q <= {w_p0[2*PRECISION-1], w_p0} - {w_p1[2*PRECISION-1], w_p1};
    end
  end

  assign w_cull = area_q[2*PRECISION] || (area_q == '0);
`else
  assign w_cull = 1'b0;
`endif

  assign w_empty   = w_box_empty || w_cull;
  assign w_accept  = tri_vld_i && tri_rdy_o;
  assign w_is_last = (px_q == xmax_q) && (py_q == ymax_q);
  assign w_emit    = (state_q == ST_SCAN) && !done_q && !out_stall_i;
  assign w_sx      = sample_point(px_q);
  assign w_sy      = sample_point(py_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_accept) state_d = ST_SETUP;
`ifdef TRI_BACKFACE_CULL_EN
      ST_SETUP: state_d = ST_AREA;
`else
      ST_SETUP: state_d = ST_CLIP;
`endif
      ST_AREA:  state_d = ST_CLIP;
      ST_CLIP:  state_d = w_empty ? ST_IDLE : ST_SCAN;
      ST_SCAN:  if (done_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tri_rdy_o = armed_q && (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
        ax_q[i] <= '0;
        ay_q[i] <= '0;
      end
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      px_q       <= '0;
      py_q       <= '0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
      out_ax_q   <= '0;
      out_ay_q   <= '0;
      out_bx_q   <= '0;
      out_by_q   <= '0;
      out_px_q   <= '0;
      out_py_q   <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
              vx_q[i] <= fx_t'(tri_x_i[i*PRECISION +: PRECISION]);
              vy_q[i] <= fx_t'(tri_y_i[i*PRECISION +: PRECISION]);
            end
          end
        end
        ST_SETUP: begin
          for (int i = 0; i < 3; i++) begin
            ax_q[i] <= vx_q[(i+1)%3] - vx_q[i];
            ay_q[i] <= vy_q[(i+1)%3] - vy_q[i];
          end
        end
        ST_CLIP: begin
          xmin_q <= w_xmin;
          xmax_q <= w_xmax;
          ymin_q <= w_ymin;
          ymax_q <= w_ymax;
          px_q   <= w_xmin;
          py_q   <= w_ymin;
          done_q <= 1'b0;
        end
        ST_SCAN: begin
          if (w_emit) begin
            out_vld_q  <= 1'b1;
            out_last_q <= w_is_last;
            out_px_q   <= px_q;
            out_py_q   <= py_q;
            for (int i = 0; i < 3; i++) begin
              out_ax_q[i*PRECISION +: PRECISION] <= ax_q[i];
              out_ay_q[i*PRECISION +: PRECISION] <= ay_q[i];
              out_bx_q[i*PRECISION +: PRECISION] <= w_sx - vx_q[i];
              out_by_q[i*PRECISION +: PRECISION] <= w_sy - vy_q[i];
            end
            // Counters park on the last pixel; done_q lets the FSM leave next edge.
            if (w_is_last) begin
              done_q <= 1'b1;
            end else if (px_q == xmax_q) begin
              px_q <= xmin_q;
              py_q <= py_q + pix_t'(1);
            end else begin
              px_q <= px_q + pix_t'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_vld_o  = out_vld_q;
  assign out_last_o = out_last_q;
  assign out_ax_o   = out_ax_q;
  assign out_ay_o   = out_ay_q;
  assign out_bx_o   = out_bx_q;
  assign out_by_o   = out_by_q;
  assign out_px_o   = out_px_q;
  assign out_py_o   = out_py_q;

endmodule

`default_nettype wire

// File: doc/tri_pixel_scanner.md
Name: tri_pixel_scanner

Overview:
Rasterizer front end that sits directly upstream of the three edge-function cross_product instances. Accepts one triangle of three signed fixed-point vertices through a valid/ready handshake and computes its pixel bounding box clipped to the screen. Walks that box in raster order, emitting per pixel the (a, b) operand pairs for all three edges plus the pixel coordinate, with a per-pixel valid that feeds the cross_product valid input.

Parameters:
INTEGER, 10, integer bits of the fixed-point format, sign bit excluded
DECIMAL, 7, fractional bits
PRECISION, 1+INTEGER+DECIMAL, total signed width (18)
H_RES, 640, screen width in pixels
V_RES, 480, screen height in pixels

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
tri_vld  in  1  triangle valid
tri_rdy  out  1  scanner can accept a triangle
tri_x  in  3*PRECISION  vertex x, v0 in LSBs
tri_y  in  3*PRECISION  vertex y, v0 in LSBs
out_stall  in  1  downstream almost-full; pause emission
out_vld  out  1  pixel operands valid; drives cross_product in_vld
out_ax/out_ay/out_bx/out_by  out  3*PRECISION each  edge i operands in slice i
out_px  out  10  pixel x
out_py  out  10  pixel y
out_last  out  1  last pixel of the current triangle

Behaviour:
- Reset: state IDLE; out_vld=0, out_last=0, all data outputs 0, tri_rdy=0 while rst high and 1 from the first cycle after release.
- FSM: IDLE -> SETUP -> CLIP -> SCAN -> IDLE. tri_rdy=1 only in IDLE. A triangle is accepted on an edge where tri_vld && tri_rdy, and its vertices are registered there.
- SETUP, 1 cycle: edge vectors a_i = v[(i+1)%3] - v[i], both axes. Raw box = min/max of floor(v) per axis, where floor is an arithmetic shift right by DECIMAL.
- CLIP, 1 cycle: clamp the box to [0, H_RES-1] x [0, V_RES-1]. If xmax<xmin or ymax<ymin, the triangle is empty: go to IDLE and emit no pixels.
- SCAN order: x increments from xmin to xmax, then wraps to xmin with y+1; the scan ends after (xmax, ymax).
- Sample point p = (px + 0.5, py + 0.5), i.e. {px, 1'b1, 6'b0} sign-extended. Per edge: out_a_i = a_i and out_b_i = p - v[i], in PRECISION-bit two's-complement subtraction.
- Overflow: vertex span must be below 2^INTEGER per axis; beyond that results wrap and nothing is flagged.
- Outputs are registered. The first out_vld occurs on the third clock edge after the acceptance edge.
- Emission: one pixel per cycle unless out_stall is sampled high. On a stall edge, counters hold and out_vld is 0 in the following cycle; there is no loss and no duplication.
- Skid budget: the cross_product pipeline has 3 cycles of latency with no backpressure, so the consumer must raise out_stall with at least 4 entries of slack.
- out_last is 1 together with out_vld on the (xmax, ymax) pixel. On the edge after it, the FSM returns to IDLE and tri_rdy rises.
- Single-pixel box: that one pixel carries out_last=1.
- Reset asserted mid-SCAN: immediate return to IDLE, out_vld=0. The partial triangle is discarded and nothing resumes.

Optional Feature:
Macro: TRI_BACKFACE_CULL_EN.
- Defined: an AREA state is inserted between SETUP and CLIP. It computes the signed area a_0 x a_2' using one registered multiply, where a_2' = v2 - v0.
- Triangles with area <= 0 (CW or degenerate) are dropped as empty. First-pixel latency becomes 4 edges.
- Undefined: there is no AREA state, all triangles are scanned, and latency is 3.

Decomposition:
- Package raster_pkg holds: INTEGER/DECIMAL/PRECISION, H_RES/V_RES, typedef fx_t (signed PRECISION), typedef pix_t (10-bit), and the scanner state enum.
- One sub-module, bbox_clip: combinational min/max/floor/clamp of three vertices into {xmin, xmax, ymin, ymax, empty}, registered by the parent in CLIP.

Test Plan:
1. Triangle (0,0),(4,0),(0,4), no stall.
   - Exactly 25 pixels, (0,0) to (4,4) in raster order.
   - First pixel edge0: ax=512, ay=0, bx=64, by=64. Last pixel has out_last=1.
   - tri_rdy returns the cycle after.
2. Vertices (-5,-5),(700,0),(0,500).
   - Box clipped to 0..639 x 0..479: 307200 pixels.
   - First is (0,0); last is (639,479) with out_last.
3. Vertices (-10,-10),(-5,-10),(-10,-5) -> empty box: zero out_vld pulses, tri_rdy high again 3 cycles after acceptance.
4. Test 1 with out_stall held high for 5 cycles starting at the 7th pixel -> out_vld gaps exactly 5 cycles, 25 unique pixels, no repeats.
5. rst pulsed at pixel 10 of test 1.
   - out_vld=0 immediately. tri_rdy=1 one cycle after release.
   - A new triangle then scans correctly from its xmin, ymin.
6. With TRI_BACKFACE_CULL_EN: (0,0),(0,4),(4,0) produces zero pixels, while (0,0),(4,0),(0,4) produces 25 pixels with first out_vld 4 edges after acceptance.
